// File: rtl/rx_bit_scheduler_if.sv
// Bundle of the scheduler's control inputs and sample/status outputs.
// The master side (tick generator, line, host) drives the inputs and the
// slave side (the scheduler) drives the strobes.
interface rx_bit_scheduler_if;
    logic       enable_i;
    logic       baud_tick_i;
    logic       rx_i;
    logic       parity_en_i;
    logic       stop2_i;
    logic       sample_o;
    logic       sample_bit_o;
    logic [1:0] bit_type_o;
    logic [3:0] bit_index_o;
    logic       busy_o;
    logic       frame_done_o;
    logic       frame_err_o;
    logic       false_start_o;

    modport master (
        output enable_i, baud_tick_i, rx_i, parity_en_i, stop2_i,
        input  sample_o, sample_bit_o, bit_type_o, bit_index_o,
               busy_o, frame_done_o, frame_err_o, false_start_o
    );

    modport slave (
        input  enable_i, baud_tick_i, rx_i, parity_en_i, stop2_i,
        output sample_o, sample_bit_o, bit_type_o, bit_index_o,
               busy_o, frame_done_o, frame_err_o, false_start_o
    );
endinterface

// File: rtl/rx_bit_scheduler.sv
// UART receive sample sequencer: finds the start edge, validates the start
// bit at mid-bit, then strobes one mid-bit sample per data/parity/stop bit.
//
// state  | meaning
// IDLE   | waiting for a falling edge on rx while enabled
// START  | counting half a bit to check the start bit is still low
// DATA   | one sample per data bit, LSB first
// PARITY | single parity-bit sample
// STOP   | one or two stop-bit samples, last one ends the frame
module rx_bit_scheduler #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    rx_bit_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] MID_CNT   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       idx, idx_nxt;
    logic             par_lat, par_lat_nxt;
    logic             stop2_lat, stop2_lat_nxt;
    logic             rx_dly;
    logic             fall;
    logic             at_point;

    logic             sample_q, sample_nxt;
    logic             bit_q, bit_nxt;
    logic [1:0]       type_q, type_nxt;
    logic [3:0]       index_q, index_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             err_q, err_nxt;
    logic             fs_q, fs_nxt;

    // The start bit is judged at half a bit, every later bit at a full bit.
    assign fall     = !bus.rx_i && rx_dly;
    assign at_point = bus.baud_tick_i &&
                      ((state == START) ? (cnt == MID_CNT) : (cnt == LAST_CNT));

    // Line history runs in every state so a line held low cannot retrigger.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rx_dly <= 1'b1;
        else          rx_dly <= bus.rx_i;
    end

    // State, counters, latched frame format and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            par_lat   <= 1'b0;
            stop2_lat <= 1'b0;
            sample_q  <= 1'b0;
            bit_q     <= 1'b0;
            type_q    <= 2'd0;
            index_q   <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            par_lat   <= par_lat_nxt;
            stop2_lat <= stop2_lat_nxt;
            sample_q  <= sample_nxt;
            bit_q     <= bit_nxt;
            type_q    <= type_nxt;
            index_q   <= index_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
            fs_q      <= fs_nxt;
        end
    end

    // Next-state and strobe decode; strobes default low, tags hold.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        idx_nxt       = idx;
        par_lat_nxt   = par_lat;
        stop2_lat_nxt = stop2_lat;
        sample_nxt    = 1'b0;
        bit_nxt       = bit_q;
        type_nxt      = type_q;
        index_nxt     = index_q;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        fs_nxt        = 1'b0;

        if (state == IDLE) begin
            if (bus.enable_i && fall) begin
                state_nxt     = START;
                cnt_nxt       = '0;
                idx_nxt       = 4'd0;
                par_lat_nxt   = bus.parity_en_i;
                stop2_lat_nxt = bus.stop2_i;
            end
        end else if (!bus.enable_i) begin
            state_nxt = IDLE;
        end else if (bus.baud_tick_i) begin
            if (!at_point) begin
                cnt_nxt = cnt + CNT_W'(1);
            end else begin
                cnt_nxt = '0;
                case (state)
                    START: begin
                        if (bus.rx_i) begin
                            fs_nxt    = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DATA;
                            idx_nxt   = 4'd0;
                        end
                    end
                    DATA: begin
                        sample_nxt = 1'b1;
                        bit_nxt    = bus.rx_i;
                        type_nxt   = 2'd0;
                        index_nxt  = idx;
                        if (idx == LAST_DATA) begin
                            idx_nxt   = 4'd0;
                            state_nxt = par_lat ? PARITY : STOP;
                        end else begin
                            idx_nxt = idx + 4'd1;
                        end
                    end
                    PARITY: begin
                        sample_nxt = 1'b1;
                        bit_nxt    = bus.rx_i;
                        type_nxt   = 2'd1;
                        index_nxt  = 4'd0;
                        idx_nxt    = 4'd0;
                        state_nxt  = STOP;
                    end
                    STOP: begin
                        sample_nxt = 1'b1;
                        bit_nxt    = bus.rx_i;
                        type_nxt   = 2'd2;
                        index_nxt  = idx;
                        err_nxt    = !bus.rx_i;
                        if (idx == {3'd0, stop2_lat}) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            idx_nxt = idx + 4'd1;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end

        // Busy stays up through the cycle that shows the terminating pulse.
        busy_nxt = (state_nxt != IDLE) || fs_nxt || done_nxt;
    end

    assign bus.sample_o      = sample_q;
    assign bus.sample_bit_o  = bit_q;
    assign bus.bit_type_o    = type_q;
    assign bus.bit_index_o   = index_q;
    assign bus.busy_o        = busy_q;
    assign bus.frame_done_o  = done_q;
    assign bus.frame_err_o   = err_q;
    assign bus.false_start_o = fs_q;
endmodule

// File: tb/tb_rx_bit_scheduler.sv
// Bench for rx_bit_scheduler: drives whole UART frames on the line, logs every
// strobe with its cycle number, and compares against expected events computed
// from the recorded baud-tick pattern and the intended frame contents.
module tb_rx_bit_scheduler;
    localparam int DATA_BITS = 8;
    localparam int OVS       = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    rx_bit_scheduler_if bus();

    rx_bit_scheduler #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVS)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic        smp;
        logic [1:0]  typ;
        logic [3:0]  idx;
        logic        bitv;
        logic        done;
        logic        err;
        logic        fs;
    } ev_t;

    ev_t act_q[$];
    ev_t exp_q[$];
    bit  tick_log[$];
    int  cyc   = 0;
    int  per   = 1;
    int  ph    = 0;
    int  tests = 0;
    int  fails = 0;

    // Event logger: one entry per cycle that shows any strobe.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (bus.sample_o || bus.frame_done_o || bus.frame_err_o || bus.false_start_o) begin
            e.cyc  = 32'(cyc);
            e.smp  = bus.sample_o;
            e.typ  = bus.sample_o ? bus.bit_type_o : 2'd0;
            e.idx  = bus.sample_o ? bus.bit_index_o : 4'd0;
            e.bitv = bus.sample_o ? bus.sample_bit_o : 1'b0;
            e.done = bus.frame_done_o;
            e.err  = bus.frame_err_o;
            e.fs   = bus.false_start_o;
            act_q.push_back(e);
        end
    end

    function automatic string ev_str(input ev_t x);
        return $sformatf("cyc=%0d smp=%b type=%0d idx=%0d bit=%b done=%b err=%b fs=%b",
                         x.cyc, x.smp, x.typ, x.idx, x.bitv, x.done, x.err, x.fs);
    endfunction

    function automatic logic [10:0] out_vec();
        return {bus.sample_o, bus.sample_bit_o, bus.bit_type_o, bus.bit_index_o,
                bus.busy_o, bus.frame_done_o, bus.frame_err_o, bus.false_start_o};
    endfunction

    // One clock cycle with line level rx_v; the tick follows the period/phase.
    task automatic cycle(input logic rx_v);
        @(posedge clk);
        #1;
        cyc++;
        bus.rx_i        = rx_v;
        bus.baud_tick_i = ((cyc % per) == ph);
        tick_log.push_back(bus.baud_tick_i);
    endtask

    task automatic drive_bit(input logic v);
        repeat (OVS * per) cycle(v);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input bit pbit,
                              input bit st2, input bit [1:0] stopv, input int lead,
                              input logic tail_lvl, input int tail, output int e);
        bus.parity_en_i = par;
        bus.stop2_i     = st2;
        repeat (lead) cycle(1'b1);
        e = cyc + 1;
        drive_bit(1'b0);
        // Format pins wander mid-frame; the frame must keep its latched format.
        bus.parity_en_i = 1'($urandom);
        bus.stop2_i     = 1'($urandom);
        for (int j = 0; j < DATA_BITS; j++) drive_bit(d[j]);
        if (par) drive_bit(pbit);
        drive_bit(stopv[0]);
        if (st2) drive_bit(stopv[1]);
        repeat (tail) cycle(tail_lvl);
    endtask

    // Reference: sample s of a frame (s=0 start) lands on counted tick
    // OVS/2 + OVS*s after the edge; its strobe shows one cycle later.
    task automatic model_frame(input int e, input logic [7:0] d, input bit par,
                               input bit pbit, input bit st2, input bit [1:0] stopv,
                               input int max_ev);
        int  n_samp;
        int  s;
        int  ticks;
        int  k;
        int  j;
        int  made;
        ev_t x;
        n_samp = 1 + DATA_BITS + int'(par) + 1 + int'(st2);
        s      = 0;
        ticks  = 0;
        made   = 0;
        for (int c = e + 1; c < tick_log.size() && s < n_samp; c++) begin
            if (tick_log[c]) begin
                ticks++;
                if (ticks == OVS / 2 + OVS * s) begin
                    if (s > 0 && made < max_ev && c + 1 < cyc) begin
                        k      = s - 1;
                        x      = '0;
                        x.cyc  = 32'(c + 1);
                        x.smp  = 1'b1;
                        if (k < DATA_BITS) begin
                            x.typ  = 2'd0;
                            x.idx  = 4'(k);
                            x.bitv = d[k];
                        end else if (par && k == DATA_BITS) begin
                            x.typ  = 2'd1;
                            x.idx  = 4'd0;
                            x.bitv = pbit;
                        end else begin
                            j      = k - DATA_BITS - int'(par);
                            x.typ  = 2'd2;
                            x.idx  = 4'(j);
                            x.bitv = stopv[j];
                            x.err  = !stopv[j];
                            x.done = (j == int'(st2));
                        end
                        exp_q.push_back(x);
                        made++;
                    end
                    s++;
                end
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        bus.enable_i    = 1'b1;
        bus.parity_en_i = 1'b0;
        bus.stop2_i     = 1'b0;
        repeat (3) begin
            cycle(1'b1);
            tests++;
            if (out_vec() !== 11'd0) begin
                fails++;
                $display("FAIL reset_outputs: got %b required 0", out_vec());
            end
        end
        rst_n = 1'b1;
        repeat (4) cycle(1'b1);
        tests++;
        if (out_vec() !== 11'd0) begin
            fails++;
            $display("FAIL idle_outputs: got %b required 0", out_vec());
        end
    endtask

    task automatic test_frames();
        logic [7:0] d;
        bit         par, pbit, st2;
        bit [1:0]   stopv;
        int         e;
        for (int f = 0; f < 8; f++) begin
            if (f == 0) begin
                d = 8'hA5; par = 0; pbit = 0; st2 = 0; stopv = 2'b11;
            end else if (f == 1) begin
                d = 8'h3C; par = 1; pbit = 0; st2 = 1; stopv = 2'b11;
            end else begin
                d     = 8'($urandom);
                par   = 1'($urandom);
                pbit  = 1'($urandom);
                st2   = 1'($urandom);
                stopv = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            end
            act_q.delete();
            exp_q.delete();
            send_frame(d, par, pbit, st2, stopv, $urandom_range(2, 12), 1'b1, 20, e);
            model_frame(e, d, par, pbit, st2, stopv, 99);
            tests++;
            if (act_q.size() != exp_q.size()) begin
                fails++;
                $display("FAIL frame%0d event_count: got %0d required %0d", f, act_q.size(), exp_q.size());
            end
            for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
                tests++;
                if (act_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL frame%0d ev%0d: got %s required %s", f, i, ev_str(act_q[i]), ev_str(exp_q[i]));
                end
            end
        end
    endtask

    task automatic test_false_start();
        int   e;
        logic b1, b9, b10;
        b1 = 1'bx; b9 = 1'bx; b10 = 1'bx;
        act_q.delete();
        repeat (4) cycle(1'b1);
        e = cyc + 1;
        for (int k = 0; k < 33; k++) begin
            cycle((k < 3) ? 1'b0 : 1'b1);
            if (cyc == e + 1)  b1  = bus.busy_o;
            if (cyc == e + 9)  b9  = bus.busy_o;
            if (cyc == e + 10) b10 = bus.busy_o;
        end
        tests++;
        if (act_q.size() != 1) begin
            fails++;
            $display("FAIL false_start_count: got %0d events required 1", act_q.size());
        end else begin
            tests++;
            if (act_q[0].cyc !== 32'(e + 9) || act_q[0].fs !== 1'b1 || act_q[0].smp !== 1'b0) begin
                fails++;
                $display("FAIL false_start_event: got %s required fs at cyc=%0d, no sample", ev_str(act_q[0]), e + 9);
            end
        end
        tests++;
        if (b1 !== 1'b1 || b9 !== 1'b1 || b10 !== 1'b0) begin
            fails++;
            $display("FAIL false_start_busy: got %b%b%b required 110", b1, b9, b10);
        end
    endtask

    task automatic test_break();
        int e;
        act_q.delete();
        exp_q.delete();
        send_frame(8'h5A, 0, 0, 0, 2'b00, 4, 1'b0, 100, e);
        model_frame(e, 8'h5A, 0, 0, 0, 2'b00, 99);
        tests++;
        if (act_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL break_count: got %0d events required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (act_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL break ev%0d: got %s required %s", i, ev_str(act_q[i]), ev_str(exp_q[i]));
            end
        end
        tests++;
        if (bus.busy_o !== 1'b0) begin
            fails++;
            $display("FAIL break_busy: got %b required 0", bus.busy_o);
        end
        act_q.delete();
        exp_q.delete();
        send_frame(8'hC3, 1, 1, 0, 2'b11, 5, 1'b1, 20, e);
        model_frame(e, 8'hC3, 1, 1, 0, 2'b11, 99);
        tests++;
        if (act_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL after_break_count: got %0d events required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (act_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL after_break ev%0d: got %s required %s", i, ev_str(act_q[i]), ev_str(exp_q[i]));
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] d;
        int         e;
        d = 8'($urandom);
        act_q.delete();
        exp_q.delete();
        bus.parity_en_i = 1'b1;
        bus.stop2_i     = 1'b0;
        repeat (4) cycle(1'b1);
        e = cyc + 1;
        drive_bit(1'b0);
        for (int j = 0; j < 4; j++) drive_bit(d[j]);
        tests++;
        if (bus.busy_o !== 1'b1) begin
            fails++;
            $display("FAIL abort_busy_before: got %b required 1", bus.busy_o);
        end
        bus.enable_i = 1'b0;
        cycle(d[4]);
        cycle(d[4]);
        tests++;
        if (bus.busy_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_busy_after: got %b required 0", bus.busy_o);
        end
        for (int j = 4; j < DATA_BITS; j++) drive_bit(d[j]);
        drive_bit(1'b1);
        drive_bit(1'b1);
        repeat (10) cycle(1'b1);
        bus.enable_i = 1'b1;
        repeat (40) cycle(1'b1);
        model_frame(e, d, 1, 1, 0, 2'b01, 4);
        tests++;
        if (act_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL abort_count: got %0d events required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (act_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL abort ev%0d: got %s required %s", i, ev_str(act_q[i]), ev_str(exp_q[i]));
            end
        end
    endtask

    task automatic test_slow_tick_reset();
        logic [7:0] d;
        bit         par, pbit, st2;
        int         e;
        per = 4;
        ph  = 1;
        d   = 8'($urandom);
        act_q.delete();
        exp_q.delete();
        bus.parity_en_i = 1'b0;
        bus.stop2_i     = 1'b0;
        repeat (8) cycle(1'b1);
        e = cyc + 1;
        drive_bit(1'b0);
        for (int j = 0; j < 4; j++) drive_bit(d[j]);
        model_frame(e, d, 0, 0, 0, 2'b01, 4);
        tests++;
        if (act_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL slow_count: got %0d events required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (act_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL slow ev%0d: got %s required %s", i, ev_str(act_q[i]), ev_str(exp_q[i]));
            end
        end
        if (act_q.size() >= 2) begin
            tests++;
            if (act_q[1].cyc - act_q[0].cyc !== 32'd64) begin
                fails++;
                $display("FAIL slow_spacing: got %0d cycles required 64", act_q[1].cyc - act_q[0].cyc);
            end
        end
        rst_n = 1'b0;
        repeat (3) begin
            cycle(1'b1);
            tests++;
            if (out_vec() !== 11'd0) begin
                fails++;
                $display("FAIL midframe_reset_outputs: got %b required 0", out_vec());
            end
        end
        rst_n = 1'b1;
        repeat (6) cycle(1'b1);
        act_q.delete();
        exp_q.delete();
        d    = 8'($urandom);
        par  = 1'($urandom);
        pbit = 1'($urandom);
        st2  = 1'($urandom);
        send_frame(d, par, pbit, st2, 2'b11, 6, 1'b1, 20, e);
        model_frame(e, d, par, pbit, st2, 2'b11, 99);
        tests++;
        if (act_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL post_reset_count: got %0d events required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (act_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL post_reset ev%0d: got %s required %s", i, ev_str(act_q[i]), ev_str(exp_q[i]));
            end
        end
    endtask

    initial begin
        bus.enable_i    = 1'b1;
        bus.baud_tick_i = 1'b0;
        bus.rx_i        = 1'b1;
        bus.parity_en_i = 1'b0;
        bus.stop2_i     = 1'b0;
        tick_log.push_back(1'b0);
        test_reset();
        test_frames();
        test_false_start();
        test_break();
        test_abort();
        test_slow_tick_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
